// File: rtl/cam_capture_ctrl.sv
// Frame capture controller: sequences whole camera frames into a ping-pong frame
// store, checks frame geometry, and hands finished buffers to a single reader.
module cam_capture_ctrl #(
    parameter int PIXEL_WIDTH = 8,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int ADDR_WIDTH  = 19
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     iSTART,
    input  logic                     iSINGLE,
    input  logic                     iSTOP,
    input  logic                     iERR_CLR,
    input  logic                     iVSYNC,
    input  logic                     iHSYNC,
    input  logic                     iDE,
    input  logic [PIXEL_WIDTH-1:0]   iDATA_L,
    input  logic [PIXEL_WIDTH-1:0]   iDATA_R,
    input  logic                     iBUF_RELEASE,
    output logic                     oWR_EN,
    output logic                     oWR_BUF,
    output logic [ADDR_WIDTH-1:0]    oWR_ADDR,
    output logic [2*PIXEL_WIDTH-1:0] oWR_DATA,
    output logic                     oFRAME_DONE,
    output logic                     oRD_VALID,
    output logic                     oRD_BUF,
    output logic                     oBUSY,
    output logic                     oERR_SIZE,
    output logic [7:0]               oDROP_CNT
);

    localparam int PX_W = $clog2(H_ACTIVE + 1);
    localparam int LN_W = $clog2(V_ACTIVE + 2);
    localparam logic [PX_W-1:0] PX_MAX = PX_W'(H_ACTIVE);
    localparam logic [LN_W-1:0] LN_MAX = LN_W'(V_ACTIVE);
    localparam logic [LN_W-1:0] LN_SAT = LN_W'(V_ACTIVE + 1);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;

    state_t                   r_state;
    logic                     r_single;
    logic                     r_stop_req;
    logic                     r_vs_d;
    logic                     r_hs_d;
    logic [1:0]               r_full;
    logic                     r_rd_buf;
    logic                     r_last_wr;
    logic                     r_wr_buf;
    logic [PX_W-1:0]          r_px;
    logic [LN_W-1:0]          r_ln;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic                     r_line_bad;
    logic                     r_wr_en;
    logic                     r_wr_buf_o;
    logic [ADDR_WIDTH-1:0]    r_wr_addr;
    logic [2*PIXEL_WIDTH-1:0] r_wr_data;
    logic                     r_frame_done;
    logic                     r_err;
    logic [7:0]               r_drop_cnt;

    logic                     w_vs_rise;
    logic                     w_vs_fall;
    logic                     w_hs_fall;
    logic                     w_rd_valid;
    logic                     w_release;
    logic                     w_alt_buf;
    logic                     w_buf_free;
    logic                     w_new_buf;
    logic                     w_px_ok;
    logic                     w_ln_ok;
    logic                     w_line_open;
    logic [LN_W-1:0]          w_ln_inc;
    logic [LN_W-1:0]          w_ln_eof;
    logic                     w_bad_eof;
    logic                     w_eof;
    logic                     w_good;
    logic [1:0]               w_full_next;
    logic                     w_rd_buf_next;

    assign w_vs_rise   = iVSYNC & ~r_vs_d;
    assign w_vs_fall   = ~iVSYNC & r_vs_d;
    assign w_hs_fall   = ~iHSYNC & r_hs_d;
    assign w_rd_valid  = r_full[r_rd_buf];
    assign w_release   = iBUF_RELEASE & w_rd_valid;

    // Prefer the buffer not written last so the reader always sees the newest frame.
    assign w_alt_buf   = ~r_last_wr;
    assign w_buf_free  = ~r_full[w_alt_buf] | ~r_full[r_last_wr];
    assign w_new_buf   = ~r_full[w_alt_buf] ? w_alt_buf : r_last_wr;

    assign w_px_ok     = (r_px < PX_MAX);
    assign w_ln_ok     = (r_ln < LN_MAX);
    assign w_line_open = (r_px != '0);
    assign w_ln_inc    = (r_ln == LN_SAT) ? r_ln : r_ln + 1'b1;

    // A last line that never saw an HSYNC fall is closed out by the VSYNC fall.
    assign w_ln_eof    = w_line_open ? w_ln_inc : r_ln;
    assign w_bad_eof   = r_line_bad | (w_line_open && (r_px != PX_MAX));
    assign w_eof       = (r_state == CAPTURE) && w_vs_fall;
    assign w_good      = w_eof && (w_ln_eof == LN_MAX) && !w_bad_eof;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        w_full_next   = r_full;
        w_rd_buf_next = r_rd_buf;
        if (w_release) begin
            w_full_next[r_rd_buf] = 1'b0;
        end
        if (w_good) begin
            w_full_next[r_wr_buf] = 1'b1;
        end
        if (w_release) begin
            if (w_full_next[~r_rd_buf]) begin
                w_rd_buf_next = ~r_rd_buf;
            end
        end else if (w_good && !w_rd_valid) begin
            w_rd_buf_next = r_wr_buf;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= IDLE;
            r_single     <= 1'b0;
            r_stop_req   <= 1'b0;
            r_vs_d       <= 1'b0;
            r_hs_d       <= 1'b0;
            r_full       <= 2'b00;
            r_rd_buf     <= 1'b0;
            r_last_wr    <= 1'b1;
            r_wr_buf     <= 1'b0;
            r_px         <= '0;
            r_ln         <= '0;
            r_addr       <= '0;
            r_line_bad   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_buf_o   <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_drop_cnt   <= 8'd0;
        end else begin
            r_vs_d       <= iVSYNC;
            r_hs_d       <= iHSYNC;
            r_wr_en      <= 1'b0;
            r_frame_done <= w_good;
            r_full       <= w_full_next;
            r_rd_buf     <= w_rd_buf_next;
            if (w_good) begin
                r_last_wr <= r_wr_buf;
            end
            if (w_eof && !w_good) begin
                r_err <= 1'b1;
            end else if (iERR_CLR) begin
                r_err <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (iSTOP) begin
                        r_state <= IDLE;
                    end else if (iSTART) begin
                        r_single <= 1'b0;
                        r_state  <= WAIT_VS;
                    end else if (iSINGLE) begin
                        r_single <= 1'b1;
                        r_state  <= WAIT_VS;
                    end
                end

                WAIT_VS: begin
                    if (iSTOP) begin
                        r_state <= IDLE;
                    end else if (w_vs_rise) begin
                        if (w_buf_free) begin
                            r_wr_buf   <= w_new_buf;
                            r_ln       <= '0;
                            r_line_bad <= 1'b0;
                            r_stop_req <= 1'b0;
                            r_state    <= CAPTURE;
                            if (iDE) begin
                                r_wr_en    <= 1'b1;
                                r_wr_buf_o <= w_new_buf;
                                r_wr_addr  <= '0;
                                r_wr_data  <= {iDATA_L, iDATA_R};
                                r_px       <= PX_W'(1);
                                r_addr     <= ADDR_WIDTH'(1);
                            end else begin
                                r_px   <= '0;
                                r_addr <= '0;
                            end
                        end else if (r_drop_cnt != 8'hFF) begin
                            r_drop_cnt <= r_drop_cnt + 8'd1;
                        end
                    end
                end

                CAPTURE: begin
                    if (iSTOP) begin
                        r_stop_req <= 1'b1;
                    end
                    if (w_vs_fall) begin
                        r_state <= (r_single || r_stop_req || iSTOP) ? IDLE : WAIT_VS;
                    end else begin
                        if (iDE) begin
                            if (w_px_ok && w_ln_ok) begin
                                r_wr_en    <= 1'b1;
                                r_wr_buf_o <= r_wr_buf;
                                r_wr_addr  <= r_addr;
                                r_wr_data  <= {iDATA_L, iDATA_R};
                                r_addr     <= r_addr + 1'b1;
                            end else begin
                                r_line_bad <= 1'b1;
                            end
                        end
                        if (w_hs_fall && w_line_open) begin
                            if (r_px != PX_MAX) begin
                                r_line_bad <= 1'b1;
                            end
                            r_ln <= w_ln_inc;
                            r_px <= '0;
                        end else if (iDE && w_px_ok && w_ln_ok) begin
                            r_px <= r_px + 1'b1;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign oWR_EN      = r_wr_en;
    assign oWR_BUF     = r_wr_buf_o;
    assign oWR_ADDR    = r_wr_addr;
    assign oWR_DATA    = r_wr_data;
    assign oFRAME_DONE = r_frame_done;
    assign oRD_VALID   = w_rd_valid;
    assign oRD_BUF     = r_rd_buf;
    assign oBUSY       = (r_state != IDLE);
    assign oERR_SIZE   = r_err;
    assign oDROP_CNT   = r_drop_cnt;

endmodule
